// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the RAM and the arbiter.
// The arbiter takes the slave view; the cache/RAM side takes the master view.
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache has priority.
// Optional icache starvation guard enabled by defining CACHE_ARB_STARVE_GUARD_EN.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    cache_mem_arbiter_if.slave bus
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   err_r;
    logic   err_set_s;
    logic   dreq_s;
    logic   starve_s;

`ifdef CACHE_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_r;
    logic       icomp_s;
    logic       dcomp_s;

    assign icomp_s  = !RST && (state_r == IREAD) && bus.iREN && (bus.ramstate == RAM_ACCESS);
    assign dcomp_s  = !RST && bus.iREN && (bus.ramstate == RAM_ACCESS) &&
                      (((state_r == DREAD) && bus.dREN) || ((state_r == DWRITE) && bus.dWEN));
    assign starve_s = ({29'd0, starve_cnt_r} >= $unsigned(STARVE_LIMIT));

    // Count dcache completions that made a waiting icache request sit out; saturates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_r <= 3'd0;
        end else if (icomp_s) begin
            starve_cnt_r <= 3'd0;
        end else if (dcomp_s && (starve_cnt_r != 3'd7)) begin
            starve_cnt_r <= starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starve_s = 1'b0;
`endif

    assign dreq_s  = bus.dREN | bus.dWEN;
    assign bus.err = err_r;

    // State register and sticky RAM error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= err_r | err_set_s;
        end
    end

    // Next-state decode and combinational RAM/cache-side outputs.
    always_comb begin
        next_state_s = state_r;
        err_set_s    = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iwait    = bus.iREN;
        bus.dwait    = dreq_s;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;
        if (RST) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dreq_s && !(starve_s && bus.iREN)) begin
                        next_state_s = bus.dWEN ? DWRITE : DREAD;
                    end else if (bus.iREN) begin
                        next_state_s = IREAD;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                IREAD: begin
                    bus.iwait = 1'b1;
                    bus.dwait = 1'b1;
                    if (!bus.iREN) begin
                        next_state_s = IDLE;
                    end else begin
                        bus.ramREN  = 1'b1;
                        bus.ramaddr = bus.iaddr;
                        case (bus.ramstate)
                            RAM_ACCESS: begin
                                bus.iwait    = 1'b0;
                                bus.iload    = bus.ramload;
                                next_state_s = IDLE;
                            end
                            RAM_ERROR: begin
                                err_set_s    = 1'b1;
                                next_state_s = IDLE;
                            end
                            default: next_state_s = state_r;
                        endcase
                    end
                end
                DREAD, DWRITE: begin
                    bus.iwait = 1'b1;
                    bus.dwait = 1'b1;
                    // A read grant lives on dREN, a write grant on dWEN.
                    if ((state_r == DREAD) ? !bus.dREN : !bus.dWEN) begin
                        next_state_s = IDLE;
                    end else begin
                        bus.ramREN   = (state_r == DREAD);
                        bus.ramWEN   = (state_r == DWRITE);
                        bus.ramaddr  = bus.daddr;
                        bus.ramstore = bus.dstore;
                        case (bus.ramstate)
                            RAM_ACCESS: begin
                                bus.dwait    = 1'b0;
                                bus.dload    = (state_r == DREAD) ? bus.ramload : 32'd0;
                                next_state_s = IDLE;
                            end
                            RAM_ERROR: begin
                                err_set_s    = 1'b1;
                                next_state_s = IDLE;
                            end
                            default: next_state_s = state_r;
                        endcase
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed table-driven bench for cache_mem_arbiter plus a starvation sequence.
module tb_cache_mem_arbiter;

    logic CLK;
    logic RST;
    int   pass_cnt;
    int   chk_cnt;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  ramstate;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_raddr;
        logic [31:0] e_rstore;
        logic        e_err;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic rst, input logic iren, input logic [31:0] iaddr,
        input logic dren, input logic dwen, input logic [31:0] daddr,
        input logic [31:0] dstore, input logic [31:0] ramload, input logic [1:0] ramstate,
        input logic e_iwait, input logic [31:0] e_iload, input logic e_dwait,
        input logic [31:0] e_dload, input logic e_ren, input logic e_wen,
        input logic [31:0] e_raddr, input logic [31:0] e_rstore, input logic e_err);
        vec_t v;
        v.rst = rst; v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen;
        v.daddr = daddr; v.dstore = dstore; v.ramload = ramload; v.ramstate = ramstate;
        v.e_iwait = e_iwait; v.e_iload = e_iload; v.e_dwait = e_dwait; v.e_dload = e_dload;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_raddr = e_raddr; v.e_rstore = e_rstore;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        RST          = v.rst;
        bus.iREN     = v.iren;
        bus.iaddr    = v.iaddr;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.daddr    = v.daddr;
        bus.dstore   = v.dstore;
        bus.ramload  = v.ramload;
        bus.ramstate = v.ramstate;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [132:0] act;
        logic [132:0] exp;
        act = {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err,
               bus.iload, bus.dload, bus.ramaddr, bus.ramstore};
        exp = {v.e_iwait, v.e_dwait, v.e_ren, v.e_wen, v.e_err,
               v.e_iload, v.e_dload, v.e_raddr, v.e_rstore};
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL vec%0d {iwait,dwait,ren,wen,err,iload,dload,raddr,rstore} got %h expected %h",
                     idx, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        pass_cnt = 0;
        chk_cnt  = 0;

        //         rst  iren iaddr         dren dwen daddr         dstore        ramload       st     iw   iload         dw   dload         ren  wen  raddr         rstore        err
        tbl[0]  = mk(1'b1,1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b1,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[1]  = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[2]  = mk(1'b0,1'b1,32'h40,      1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b1,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[3]  = mk(1'b0,1'b1,32'h40,      1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd1, 1'b1,32'h0,       1'b1,32'h0,       1'b1,1'b0,32'h40,      32'h0,       1'b0);
        tbl[4]  = mk(1'b0,1'b1,32'h40,      1'b0,1'b0,32'h0,       32'h0,       32'hDEADBEEF,2'd2, 1'b0,32'hDEADBEEF,1'b1,32'h0,       1'b1,1'b0,32'h40,      32'h0,       1'b0);
        tbl[5]  = mk(1'b0,1'b0,32'h40,      1'b0,1'b0,32'h0,       32'h0,       32'hDEADBEEF,2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[6]  = mk(1'b0,1'b0,32'h0,       1'b1,1'b1,32'h80,      32'h1234,    32'h0,       2'd0, 1'b0,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[7]  = mk(1'b0,1'b0,32'h0,       1'b1,1'b1,32'h80,      32'h1234,    32'h0,       2'd2, 1'b1,32'h0,       1'b0,32'h0,       1'b0,1'b1,32'h80,      32'h1234,    1'b0);
        tbl[8]  = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[9]  = mk(1'b0,1'b0,32'h0,       1'b1,1'b0,32'h100,     32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[10] = mk(1'b0,1'b0,32'h0,       1'b1,1'b0,32'h100,     32'h0,       32'h0,       2'd3, 1'b1,32'h0,       1'b1,32'h0,       1'b1,1'b0,32'h100,     32'h0,       1'b0);
        tbl[11] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[12] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[13] = mk(1'b0,1'b1,32'h44,      1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b1,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[14] = mk(1'b0,1'b0,32'h44,      1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd1, 1'b1,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[15] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h77,      2'd2, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[16] = mk(1'b0,1'b1,32'h48,      1'b1,1'b0,32'h200,     32'h0,       32'h0,       2'd0, 1'b1,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[17] = mk(1'b0,1'b1,32'h48,      1'b1,1'b0,32'h200,     32'h0,       32'h0,       2'd1, 1'b1,32'h0,       1'b1,32'h0,       1'b1,1'b0,32'h200,     32'h0,       1'b1);
        tbl[18] = mk(1'b0,1'b1,32'h48,      1'b1,1'b0,32'h200,     32'h0,       32'hCAFE0001,2'd2, 1'b1,32'h0,       1'b0,32'hCAFE0001,1'b1,1'b0,32'h200,     32'h0,       1'b1);
        tbl[19] = mk(1'b0,1'b1,32'h48,      1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b1,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[20] = mk(1'b0,1'b1,32'h48,      1'b0,1'b0,32'h0,       32'h0,       32'h00C0FFEE,2'd2, 1'b0,32'h00C0FFEE,1'b1,32'h0,       1'b1,1'b0,32'h48,      32'h0,       1'b1);
        tbl[21] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[22] = mk(1'b0,1'b0,32'h0,       1'b0,1'b1,32'h300,     32'h55AA,    32'h0,       2'd0, 1'b0,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[23] = mk(1'b0,1'b0,32'h0,       1'b0,1'b1,32'h300,     32'h55AA,    32'h0,       2'd1, 1'b1,32'h0,       1'b1,32'h0,       1'b0,1'b1,32'h300,     32'h55AA,    1'b1);
        tbl[24] = mk(1'b1,1'b0,32'h0,       1'b0,1'b1,32'h300,     32'h55AA,    32'h0,       2'd1, 1'b0,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b1);
        tbl[25] = mk(1'b0,1'b0,32'h0,       1'b0,1'b1,32'h300,     32'h55AA,    32'h0,       2'd2, 1'b0,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[26] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h300,     32'h55AA,    32'h0,       2'd0, 1'b1,32'h0,       1'b1,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);
        tbl[27] = mk(1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       2'd0, 1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,32'h0,       32'h0,       1'b0);

        // Put the state register and err flag into a known value first.
        apply(tbl[0]);
        @(posedge CLK);
        #1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            #2;
            check_vec(i, tbl[i]);
            @(posedge CLK);
            #1;
        end

        // Starvation: icache held while dcache requests back-to-back, RAM always ready.
        apply(tbl[0]);
        @(posedge CLK);
        #1;
        RST          = 1'b0;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h600;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h500;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h11;
        bus.ramstate = 2'd2;
        for (int g = 0; g < 5; g++) begin
            #2;
            check32($sformatf("starve_idle%0d_strobes", g), {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
            @(posedge CLK);
            #1;
            #2;
            exp_addr = 32'h500;
`ifdef CACHE_ARB_STARVE_GUARD_EN
            if (g == 4) begin
                exp_addr = 32'h600;
            end else begin
                exp_addr = 32'h500;
            end
`endif
            check32($sformatf("starve_grant%0d_addr", g), bus.ramaddr, exp_addr);
            @(posedge CLK);
            #1;
        end
        check32("starve_err", {31'd0, bus.err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
